sat_clause_loader: RTL and testbench

- Upstream front-end for the brute-force 3-SAT solver core.
- Accepts clauses one at a time over a valid/ready stream and buffers up to NUM_CLAUSES of them.
- Replays them in the solver's column-major nibble load order: 16 dummy slots, then every lit1, then every lit2, then every lit3.
- Then runs the solver until it reports done, and latches the verdict and the final assignment.

---
 rtl/sat_clause_loader.sv | 160 ++++++++++++++++
 tb/tb_sat_clause_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sat_clause_loader.sv
// Front-end for the brute-force 3-SAT solver. It buffers clauses from a valid/ready
// stream, replays them in column-major nibble order, runs the solver and latches the verdict.
module sat_clause_loader #(
  parameter int NUM_CLAUSES      = 16,
  parameter int LOG2_NUM_CLAUSES = 4,
  parameter int LIT_BITS         = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3*LIT_BITS-1:0] in_clause,
  input  logic                  in_last,
  output logic                  sat_reset,
  output logic                  sat_load,
  output logic                  sat_run,
  output logic [LIT_BITS-1:0]   sat_data,
  input  logic                  sat_done,
  input  logic                  sat_sol,
  input  logic [3:0]            sat_x,
  output logic                  busy,
  output logic                  result_valid,
  output logic                  result_sat,
  output logic [3:0]            result_x
);

  localparam int CNT_W = LOG2_NUM_CLAUSES + 1;
  localparam int PTR_W = LOG2_NUM_CLAUSES + 2;
  localparam int CL_W  = 3 * LIT_BITS;

  typedef enum logic [2:0] {IDLE, COLLECT, STREAM, RUN, DONE} state_t;

  state_t                        state;
  logic [CL_W-1:0]               clause_buf [NUM_CLAUSES];
  logic [CNT_W-1:0]              count;
  logic [PTR_W-1:0]              ptr;
  logic                          hold;

  logic                          accept;
  logic                          last_slot;
  logic [LOG2_NUM_CLAUSES-1:0]   wr_addr;
  logic [PTR_W-1:0]              ptr_next;
  logic [1:0]                    col_next;
  logic [LOG2_NUM_CLAUSES-1:0]   row_next;
  logic [CL_W-1:0]               src_clause;
  logic [LIT_BITS-1:0]           next_nibble;

  assign accept    = in_valid && in_ready;
  assign last_slot = (count == CNT_W'(NUM_CLAUSES - 1));
  assign wr_addr   = (state == DONE) ? '0 : count[LOG2_NUM_CLAUSES-1:0];

  // NOTE: the clause buffer has no reset; rows at or above count are never read,
  // so stale contents are harmless and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (accept) clause_buf[wr_addr] <= in_clause;
  end

  // sat_data is registered, so the lookup is done one slot ahead of ptr.
  always_comb begin
    ptr_next    = ptr + 1'b1;
    col_next    = ptr_next[PTR_W-1 -: 2];
    row_next    = ptr_next[LOG2_NUM_CLAUSES-1:0];
    src_clause  = ({1'b0, row_next} < count) ? clause_buf[row_next] : clause_buf[0];
    next_nibble = '0;
    case (col_next)
      2'd1:    next_nibble = src_clause[LIT_BITS-1:0];
      2'd2:    next_nibble = src_clause[2*LIT_BITS-1:LIT_BITS];
      2'd3:    next_nibble = src_clause[3*LIT_BITS-1:2*LIT_BITS];
      default: next_nibble = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      count        <= '0;
      ptr          <= '0;
      hold         <= 1'b0;
      in_ready     <= 1'b1;
      sat_reset    <= 1'b1;
      sat_load     <= 1'b0;
      sat_run      <= 1'b0;
      sat_data     <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_sat   <= 1'b0;
      result_x     <= '0;
    end else begin
      unique case (state)
        IDLE, COLLECT: begin
          if (accept) begin
            count <= count + 1'b1;
            if (in_last || last_slot) begin
              state     <= STREAM;
              ptr       <= '0;
              hold      <= 1'b0;
              in_ready  <= 1'b0;
              busy      <= 1'b1;
              sat_reset <= 1'b0;
              sat_load  <= 1'b1;
              sat_data  <= '0;
            end else begin
              state <= COLLECT;
            end
          end
        end

        STREAM: begin
          if (hold) begin
            // Leaving DONE straight into STREAM: one solver reset cycle precedes slot 0.
            hold      <= 1'b0;
            sat_reset <= 1'b0;
            sat_load  <= 1'b1;
            sat_data  <= '0;
          end else if (ptr == '1) begin
            state    <= RUN;
            sat_load <= 1'b0;
            sat_run  <= 1'b1;
            sat_data <= '0;
          end else begin
            ptr      <= ptr_next;
            sat_data <= next_nibble;
          end
        end

        RUN: begin
          if (sat_done) begin
            state        <= DONE;
            result_sat   <= sat_sol;
            result_x     <= sat_x;
            result_valid <= 1'b1;
            sat_run      <= 1'b0;
            busy         <= 1'b0;
            in_ready     <= 1'b1;
          end
        end

        DONE: begin
          if (accept) begin
            result_valid <= 1'b0;
            sat_reset    <= 1'b1;
            count        <= CNT_W'(1);
            if (in_last) begin
              state    <= STREAM;
              ptr      <= '0;
              hold     <= 1'b1;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sat_clause_loader.sv
// Self-checking bench for sat_clause_loader: scenario table, nibble scoreboard,
// stub solver and an asynchronous reset in the middle of a stream.
module tb_sat_clause_loader;

  localparam int N  = 16;
  localparam int LB = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3*LB-1:0] in_clause = '0;
  logic          in_last = 1'b0;
  logic          sat_reset, sat_load, sat_run;
  logic [LB-1:0] sat_data;
  logic          sat_done = 1'b0;
  logic          sat_sol = 1'b0;
  logic [3:0]    sat_x = '0;
  logic          busy, result_valid, result_sat;
  logic [3:0]    result_x;

  sat_clause_loader #(.NUM_CLAUSES(N), .LOG2_NUM_CLAUSES(4), .LIT_BITS(LB)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_clause(in_clause), .in_last(in_last),
    .sat_reset(sat_reset), .sat_load(sat_load), .sat_run(sat_run), .sat_data(sat_data),
    .sat_done(sat_done), .sat_sol(sat_sol), .sat_x(sat_x),
    .busy(busy), .result_valid(result_valid), .result_sat(result_sat), .result_x(result_x)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    bit         last;
    int         run_cycles;
    bit         sol;
    logic [3:0] x;
    bit         exp_sat;
    logic [3:0] exp_x;
  } vec_t;

  int            n_vec  = 0;
  int            n_miss = 0;
  logic [11:0]   cl [N];
  logic [3:0]    exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic build_expect(input int n);
    logic [11:0] c;
    exp_q.delete();
    for (int col = 0; col < 4; col++) begin
      for (int row = 0; row < N; row++) begin
        c = (row < n) ? cl[row] : cl[0];
        case (col)
          0:       exp_q.push_back(4'h0);
          1:       exp_q.push_back(c[3:0]);
          2:       exp_q.push_back(c[7:4]);
          default: exp_q.push_back(c[11:8]);
        endcase
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the final accept.
  task automatic send_all(input int n, input bit last);
    bit was_done;
    was_done = result_valid;
    for (int i = 0; i < n; i++) begin
      cl[i] = 12'($urandom);
      check("in_ready_before_accept", in_ready, 1);
      in_valid  = 1'b1;
      in_clause = cl[i];
      in_last   = last && (i == n - 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (i == 0) begin
        check("result_valid_cleared", result_valid, 0);
        if (was_done || n > 1) check("sat_reset_held", sat_reset, 1);
      end
    end
    check("in_ready_dropped", in_ready, 0);
  endtask

  task automatic check_stream(input int n);
    int b;
    logic [3:0] e;
    build_expect(n);
    b = 0;
    while (!sat_load && b < 4) begin
      @(negedge clk);
      b++;
    end
    check("stream_start", sat_load, 1);
    check("count_reg", dut.count, n);
    in_valid  = 1'b1;
    in_clause = 12'hFFF;
    for (int k = 0; k < 4 * N; k++) begin
      e = exp_q.pop_front();
      check($sformatf("nibble_%0d", k), {sat_load, sat_reset, sat_data}, {1'b1, 1'b0, e});
      if (k < 4 * N - 1) @(negedge clk);
    end
    @(negedge clk);
    check("load_off_run_on", {sat_load, sat_run, busy, in_ready}, 4'b0110);
  endtask

  task automatic run_solver(input vec_t v);
    repeat (v.run_cycles - 1) @(negedge clk);
    check("run_held", {sat_run, result_valid}, 2'b10);
    sat_done  = 1'b1;
    sat_sol   = v.sol;
    sat_x     = v.x;
    in_valid  = 1'b0;
    @(negedge clk);
    sat_done = 1'b0;
    sat_sol  = ~v.sol;
    sat_x    = ~v.x;
    check("run_fell", sat_run, 0);
    check("result_valid", result_valid, 1);
    check("result_sat", result_sat, v.exp_sat);
    check("result_x", result_x, v.exp_x);
    check("done_busy_ready", {busy, in_ready, sat_reset}, 3'b010);
    @(negedge clk);
    check("result_frozen", {result_sat, result_x}, {v.exp_sat, v.exp_x});
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{n: 16, last: 1'b0, run_cycles: 40, sol: 1'b1, x: 4'hA, exp_sat: 1'b1, exp_x: 4'hA};
    vecs[1] = '{n: 3,  last: 1'b1, run_cycles: 40, sol: 1'b0, x: 4'hF, exp_sat: 1'b0, exp_x: 4'hF};
    vecs[2] = '{n: 1,  last: 1'b1, run_cycles: 3,  sol: 1'b1, x: 4'h5, exp_sat: 1'b1, exp_x: 4'h5};
    vecs[3] = '{n: 16, last: 1'b1, run_cycles: 10, sol: 1'b0, x: 4'h0, exp_sat: 1'b0, exp_x: 4'h0};
    vecs[4] = '{n: 9,  last: 1'b1, run_cycles: 1,  sol: 1'b1, x: 4'h6, exp_sat: 1'b1, exp_x: 4'h6};

    repeat (2) @(negedge clk);
    check("rst_ready_reset_load", {in_ready, sat_reset, sat_load, sat_run}, 4'b1100);
    check("rst_data", sat_data, 0);
    check("rst_status", {busy, result_valid, result_sat, result_x}, 7'b0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      send_all(vecs[i].n, vecs[i].last);
      check_stream(vecs[i].n);
      run_solver(vecs[i]);
    end

    // Asynchronous reset in the middle of a stream, at ptr 30.
    send_all(16, 1'b0);
    check("abort_stream_start", sat_load, 1);
    repeat (30) @(negedge clk);
    check("abort_ptr", dut.ptr, 30);
    reset_n = 1'b0;
    #1;
    check("async_rst_outputs", {sat_load, sat_reset, in_ready, busy, sat_run}, 5'b01100);
    check("async_rst_result", {result_valid, sat_data}, 5'b0);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_all(vecs[1].n, vecs[1].last);
    check_stream(vecs[1].n);
    run_solver(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
